irq_priority_ctrl: RTL and testbench
====================================

// Module: irq_priority_ctrl
// PURPOSE
//  Interrupt front end feeding a 4-to-2 priority encode: synchronises 4 raw request lines, latches them as
//  pending, masks with an enable register, presents the highest-index eligible request as a 2-bit id
//  with a valid/ready handshake, then holds off further requests until end-of-interrupt (eoi) or timeout.
// PARAMETERS
//  SYNC_STAGES  2    flops per request synchroniser (>=2)
//  SVC_TIMEOUT  255  cycles allowed in SERVICE before forced return to IDLE; 0 = no timeout
// PORTS
//  clock      in   1  single clock, all logic rising-edge
//  n_reset    in   1  asynchronous, active-low reset
//  req        in   4  raw asynchronous request lines, bit 3 highest priority
//  mask_wr    in   1  load enable register from mask_in
//  mask_in    in   4  new enable value (1 = request eligible)
//  irq_valid  out  1  irq_id valid (PRESENT state)
//  irq_ready  in   1  consumer accepts irq_id
//  irq_id     out  2  index of presented request
//  eoi        in   1  end of interrupt, honoured in SERVICE only
//  pending    out  4  pending register
//  busy       out  1  high in SERVICE
//  timeout    out  1  one-cycle pulse on SERVICE timeout
// BEHAVIOUR
//  Reset: sync flops, pending, irq_valid, irq_id, busy, timeout, counter = 0; enable = 4'b1111; state IDLE.
//  Reset mid-operation discards all pending and in-service state immediately.
//  Sync: req through SYNC_STAGES flops -> req_s. Pending set independent of enable.
//  eligible = pending & enable; encode: highest set index wins (1??? ->3, 01?? ->2, 001? ->1, 0001 ->0).
//  mask_wr: enable <= mask_in at next edge; does not alter pending or a presented id.
//  FSM (state_t): IDLE, PRESENT, SERVICE.
//   IDLE: |eligible -> PRESENT; irq_id <= encode(eligible), irq_valid <= 1 at same edge.
//   PRESENT: irq_id stable until accepted; later higher-priority arrivals or mask writes never change or
//    withdraw it. irq_valid & irq_ready -> SERVICE: clear pending[irq_id], irq_valid <= 0, busy <= 1.
//   SERVICE: eoi -> IDLE, busy <= 0. Counter counts cycles from accept; if SVC_TIMEOUT != 0 and counter
//    reaches SVC_TIMEOUT with no eoi -> IDLE, timeout = 1 for one cycle. eoi and expiry same cycle: eoi wins,
//    no pulse. Counter width $clog2(SVC_TIMEOUT+1), cleared on entering SERVICE.
//   eoi outside SERVICE is ignored. IDLE lasts >=1 cycle between services.
//  Same-cycle set and clear of one pending bit: set wins.
//  Latency: first edge sampling req high = edge k; pending bit set at edge k+SYNC_STAGES;
//   irq_valid high after edge k+SYNC_STAGES+1 (both modes). Accept-to-busy: 1 edge.
// CONFIGURATION
//  IRQ_EDGE_DETECT_EN defined: extra flop req_q; pending[i] set on req_s[i] & ~req_q[i] (one event per
//   rising edge; a held request is serviced once).
//  Undefined: level mode; pending[i] set every cycle req_s[i] = 1 (held request re-presents after eoi).
// STRUCTURE
//  Package irq_pkg: NUM_IRQ = 4, ID_W = 2, typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t.
//  One sub-module: irq_prio_enc (combinational 4->2 priority encode of eligible, plus any flag); top holds
//  synchronisers, pending/enable registers, FSM and timeout counter.
// TESTING
//  1 req=4'b0100 held 3 cycles, edge mode -> pending=0100, irq_valid after edge k+3, irq_id=2; irq_ready=1
//    -> pending=0000, busy=1 next edge; eoi=1 -> busy=0, irq_valid stays 0.
//  2 req=4'b1010 simultaneously -> irq_id=3 presented, serviced, eoi; then irq_id=1; then idle.
//  3 irq_id=1 presented, ready held 0, req[3] rises -> irq_id stays 1, pending=1010; after accept+eoi
//    -> irq_id=3.
//  4 mask_wr with mask_in=4'b0111, req[3] pulse -> pending=1000, irq_valid=0; mask_in=4'b1111 -> irq_id=3.
//  5 SVC_TIMEOUT=8, accept, no eoi -> timeout pulse 8 cycles after accept, busy=0; eoi on expiry cycle
//    -> no pulse.
//  6 n_reset=0 during SERVICE -> all outputs 0, enable=1111; level mode with req[0] held -> irq_id=0
//    re-presented after each eoi.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt priority front end.
package irq_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return NUM_IRQ'(1) << id;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encode: highest set index of eligible_i wins; any_o flags a request.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] eligible_i,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    id_o = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible_i[i]) id_o = ID_W'(i);
    end
  end

  assign any_o = |eligible_i;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt front end: synchronise, latch pending, mask, present highest id, service until eoi/timeout.
// Define IRQ_EDGE_DETECT_EN for rising-edge pending capture; default is level capture.
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SVC_TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               n_reset,
  input  logic [NUM_IRQ-1:0] req,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_in,
  output logic               irq_valid,
  input  logic               irq_ready,
  output logic [ID_W-1:0]    irq_id,
  input  logic               eoi,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy,
  output logic               timeout
);

  localparam int CNT_W = (SVC_TIMEOUT > 0) ? $clog2(SVC_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (SVC_TIMEOUT > 0) ? CNT_W'(SVC_TIMEOUT - 1) : '0;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] req_s;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    enc_id;
  logic               enc_any;
  logic               accept;
  logic               expire;

  state_t             state_q;
  logic               irq_valid_q;
  logic [ID_W-1:0]    irq_id_q;
  logic               busy_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   counter_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] req_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) req_q <= '0;
    else          req_q <= req_s;
  end

  assign set_vec = req_s & ~req_q;
`else
  assign set_vec = req_s;
`endif

  assign accept    = (state_q == PRESENT) && irq_ready;
  assign clr_vec   = accept ? id_onehot(irq_id_q) : '0;
  // Set is OR-ed after the clear so a same-cycle new request is never lost.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign enable_d  = mask_wr ? mask_in : enable_q;
  assign eligible  = pending_q & enable_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      pending_q <= '0;
      enable_q  <= '1;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
    end
  end

  irq_prio_enc u_enc (
    .eligible_i (eligible),
    .id_o       (enc_id),
    .any_o      (enc_any)
  );

  generate
    if (SVC_TIMEOUT > 0) begin : g_timeout
      assign expire = (counter_q == CNT_LAST);
    end else begin : g_no_timeout
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      counter_q   <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enc_any) begin
            state_q     <= PRESENT;
            irq_valid_q <= 1'b1;
            irq_id_q    <= enc_id;
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            state_q     <= SERVICE;
            irq_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            counter_q   <= '0;
          end
        end
        SERVICE: begin
          // eoi is checked first so a coincident expiry produces no pulse.
          if (eoi) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (expire) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            counter_q <= counter_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          irq_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed scenarios with literal pins plus random traffic against a model.
module tb_irq_priority_ctrl;

  localparam int S = 2;
  localparam int T = 8;

  logic       clock = 1'b0;
  logic       n_reset;
  logic [3:0] req;
  logic       mask_wr;
  logic [3:0] mask_in;
  logic       irq_valid;
  logic       irq_ready;
  logic [1:0] irq_id;
  logic       eoi;
  logic [3:0] pending;
  logic       busy;
  logic       timeout;

  always #5 clock = ~clock;

  irq_priority_ctrl #(.SYNC_STAGES(S), .SVC_TIMEOUT(T)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .req       (req),
    .mask_wr   (mask_wr),
    .mask_in   (mask_in),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .irq_id    (irq_id),
    .eoi       (eoi),
    .pending   (pending),
    .busy      (busy),
    .timeout   (timeout)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 presenting, 2 in service.
  logic [3:0] m_hist [S];
  logic [3:0] m_prev_s;
  logic [3:0] m_pend;
  logic [3:0] m_en;
  int         m_phase;
  int         m_svc;
  logic       m_valid;
  logic [1:0] m_id;
  logic       m_busy;
  logic       m_tout;

  function automatic logic [1:0] top_index(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = 4'b0;
    m_prev_s = 4'b0;
    m_pend   = 4'b0;
    m_en     = 4'b1111;
    m_phase  = 0;
    m_svc    = 0;
    m_valid  = 1'b0;
    m_id     = 2'd0;
    m_busy   = 1'b0;
    m_tout   = 1'b0;
  endtask

  task automatic model_update();
    logic [3:0] rs;
    logic [3:0] setv;
    logic [3:0] elig;
    logic [3:0] pend_n;
    if (!n_reset) begin
      model_reset();
      return;
    end
    rs = m_hist[S-1];
`ifdef IRQ_EDGE_DETECT_EN
    setv = rs & ~m_prev_s;
`else
    setv = rs;
`endif
    elig   = m_pend & m_en;
    pend_n = m_pend;
    if (m_phase == 1 && irq_ready) pend_n[m_id] = 1'b0;
    pend_n = pend_n | setv;
    m_tout = 1'b0;
    case (m_phase)
      0: if (elig != 4'b0) begin
        m_phase = 1; m_valid = 1'b1; m_id = top_index(elig);
      end
      1: if (irq_ready) begin
        m_phase = 2; m_valid = 1'b0; m_busy = 1'b1; m_svc = 0;
      end
      default: begin
        m_svc = m_svc + 1;
        if (eoi) begin
          m_phase = 0; m_busy = 1'b0;
        end else if (m_svc == T) begin
          m_phase = 0; m_busy = 1'b0; m_tout = 1'b1;
        end
      end
    endcase
    m_pend = pend_n;
    if (mask_wr) m_en = mask_in;
    for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = req;
    m_prev_s  = rs;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk1("irq_valid", irq_valid, m_valid);
    chk4("irq_id", 4'(irq_id), 4'(m_id));
    chk4("pending", pending, m_pend);
    chk1("busy", busy, m_busy);
    chk1("timeout", timeout, m_tout);
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic wait_valid(input int max);
    for (int n = 0; n < max && !m_valid; n++) step();
    chk1("wait_valid", irq_valid, 1'b1);
  endtask

  task automatic serve(input logic [1:0] exp_id);
    wait_valid(20);
    chk4("serve_id", 4'(irq_id), 4'(exp_id));
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    chk1("serve_busy", busy, 1'b1);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk1("serve_done", busy, 1'b0);
    $display("serve id=%0d pending=%b", exp_id, pending);
  endtask

  function automatic logic model_quiet();
    logic q;
    q = (m_phase == 0) && ((m_pend & m_en) == 4'b0);
    for (int i = 0; i < S; i++) if (m_hist[i] != 4'b0) q = 1'b0;
    return q;
  endfunction

  task automatic drain();
    for (int n = 0; n < 100 && !model_quiet(); n++) begin
      irq_ready = m_valid;
      eoi       = m_busy;
      step();
    end
    irq_ready = 1'b0;
    eoi       = 1'b0;
    chk1("drain_idle", irq_valid, 1'b0);
  endtask

  task automatic pulse(input logic [3:0] v);
    req = v;
    step();
    req = 4'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0; req = 4'b0; mask_wr = 1'b0; mask_in = 4'b0;
    irq_ready = 1'b0; eoi = 1'b0;
    model_reset();
    step();
    step();
    chk4("rst_pending", pending, 4'b0000);
    chk1("rst_valid", irq_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk4("rst_id", 4'(irq_id), 4'b0000);
    n_reset = 1'b1;
    step();
    step();

    // Scenario 1: request held three cycles, latency pins.
    req = 4'b0100;
    step(); step(); step();
    chk4("t1_pending", pending, 4'b0100);
    chk1("t1_valid_early", irq_valid, 1'b0);
    req = 4'b0000;
    step();
    chk1("t1_valid", irq_valid, 1'b1);
    chk4("t1_id", 4'(irq_id), 4'd2);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    chk1("t1_busy", busy, 1'b1);
`ifdef IRQ_EDGE_DETECT_EN
    chk4("t1_pend_clr", pending, 4'b0000);
`else
    chk4("t1_pend_clr", pending, 4'b0100);
`endif
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk1("t1_eoi_busy", busy, 1'b0);
    chk1("t1_eoi_valid", irq_valid, 1'b0);
    drain();

    // Scenario 2: simultaneous requests served highest first.
    pulse(4'b1010);
    serve(2'd3);
    serve(2'd1);
    drain();

    // Scenario 3: later higher-priority arrival does not displace a presented id.
    pulse(4'b0010);
    wait_valid(20);
    chk4("t3_id_first", 4'(irq_id), 4'd1);
    pulse(4'b1000);
    repeat (4) step();
    chk4("t3_id_hold", 4'(irq_id), 4'd1);
    chk4("t3_pending", pending, 4'b1010);
    serve(2'd1);
    serve(2'd3);
    drain();

    // Scenario 4: masked request stays pending until enabled.
    mask_wr = 1'b1; mask_in = 4'b0111;
    step();
    mask_wr = 1'b0;
    pulse(4'b1000);
    repeat (4) step();
    chk4("t4_pending", pending, 4'b1000);
    chk1("t4_valid", irq_valid, 1'b0);
    mask_wr = 1'b1; mask_in = 4'b1111;
    step();
    mask_wr = 1'b0;
    serve(2'd3);
    drain();

    // Scenario 5: service timeout, then eoi on the expiry cycle.
    pulse(4'b0001);
    wait_valid(20);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    repeat (T - 1) step();
    chk1("t5_busy_before", busy, 1'b1);
    chk1("t5_no_pulse_yet", timeout, 1'b0);
    step();
    chk1("t5_pulse", timeout, 1'b1);
    chk1("t5_busy_after", busy, 1'b0);
    step();
    chk1("t5_pulse_end", timeout, 1'b0);
    pulse(4'b0001);
    wait_valid(20);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    repeat (T - 1) step();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk1("t5_eoi_wins", timeout, 1'b0);
    chk1("t5_eoi_busy", busy, 1'b0);
    drain();

    // Scenario 6: reset during service, then a held low-priority request.
    mask_wr = 1'b1; mask_in = 4'b0100;
    step();
    mask_wr = 1'b0;
    pulse(4'b0100);
    wait_valid(20);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    chk1("t6_busy", busy, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_valid", irq_valid, 1'b0);
    chk4("t6_rst_pending", pending, 4'b0000);
    step();
    n_reset = 1'b1;
    req = 4'b0001;
`ifdef IRQ_EDGE_DETECT_EN
    serve(2'd0);
    repeat (10) step();
    chk1("t6_held_once", irq_valid, 1'b0);
`else
    serve(2'd0);
    serve(2'd0);
    serve(2'd0);
`endif
    req = 4'b0000;
    drain();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      irq_ready = ($urandom_range(0, 2) != 0);
      eoi       = ($urandom_range(0, 5) == 0);
      mask_wr   = ($urandom_range(0, 30) == 0);
      mask_in   = 4'($urandom);
      n_reset   = ($urandom_range(0, 400) != 0);
      step();
    end
    n_reset = 1'b1; req = 4'b0; mask_wr = 1'b0; irq_ready = 1'b0; eoi = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
